img_frame_sched: RTL and testbench

Frame scheduler placed in front of `med_filter_proc`, the 3x3 median filter. It pulls pixels from an upstream valid/ready source and drives the filter's `per_img_vsync`/`per_img_href`/`per_img_gray` stream with programmed vertical and horizontal blanking. It then monitors the filter's `post_img_*` output and reports frame completion and pixel-count errors. Its purpose is to make frame sequencing deterministic, replacing free-running sensor timing.

---
 rtl/img_frame_sched.sv | 188 ++++++++++++++++++
 tb/tb_img_frame_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_frame_sched.sv
// img_frame_sched
// Frame scheduler in front of the 3x3 median filter. Pulls pixels from a
// valid/ready source and drives the filter input stream with programmed
// vertical and horizontal blanking. It then watches the filter output frame
// and reports completion, pixel-count errors and timeouts.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   frame_start                one-cycle request to send a frame (IDLE only)
//   src_valid, src_data        upstream pixel stream
//   src_ready                  pixel accepted this cycle (combinational)
//   per_img_vsync/href/gray    stream to the filter (registered)
//   post_img_vsync/href        filter output stream being monitored
//   busy                       high in every state except IDLE
//   frame_done                 one-cycle pulse when the output frame ends
//   pix_err                    sticky: output pixel count wrong, or timeout
//   timeout                    sticky: output frame did not end in time
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for frame_start
// VPRE     | vsync high, VS_PRE cycles before the first line
// LINE     | accepting pixels of one line (stalls while src_valid is low)
// HBLK     | HBLANK cycles of href low between lines
// VPOST    | vsync high, VS_POST cycles after the last line
// WAIT_OUT | waiting for the filter output vsync to fall, or TIMEOUT
module img_frame_sched #(
    parameter int IMG_H_DISP = 640,
    parameter int IMG_V_DISP = 480,
    parameter int VS_PRE     = 10,
    parameter int HBLANK     = 10,
    parameter int VS_POST    = 10,
    parameter int TIMEOUT    = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       src_valid,
    input  logic [7:0] src_data,
    output logic       src_ready,
    output logic       per_img_vsync,
    output logic       per_img_href,
    output logic [7:0] per_img_gray,
    input  logic       post_img_vsync,
    input  logic       post_img_href,
    output logic       busy,
    output logic       frame_done,
    output logic       pix_err,
    output logic       timeout
);
    localparam int PIX_TOTAL = IMG_H_DISP * IMG_V_DISP;
    localparam int COL_W     = $clog2(IMG_H_DISP + 1);
    localparam int ROW_W     = $clog2(IMG_V_DISP + 1);
    localparam int OCNT_W    = $clog2(PIX_TOTAL + 1);
    localparam int MAX_AB    = (VS_PRE > HBLANK) ? VS_PRE : HBLANK;
    localparam int MAX_CD    = (VS_POST > TIMEOUT) ? VS_POST : TIMEOUT;
    localparam int MAX_BLK   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int BLK_W     = $clog2(MAX_BLK + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_VPRE, S_LINE, S_HBLK, S_VPOST, S_WAIT_OUT
    } state_t;

    state_t state, next_state;

    logic [COL_W-1:0]  col_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [BLK_W-1:0]  blk_cnt;
    logic [OCNT_W-1:0] out_cnt;
    logic              post_vs_d;

    logic accept, line_end, last_row, blk_tc, vs_fall, start_ok;
    logic vsync_nxt, href_nxt, done_nxt, busy_nxt;

    assign src_ready = (state == S_LINE);
    assign accept    = src_valid & src_ready;
    assign line_end  = accept && (col_cnt == COL_W'(IMG_H_DISP - 1));
    assign last_row  = (row_cnt == ROW_W'(IMG_V_DISP - 1));
    assign blk_tc    = (blk_cnt == '0);
    assign vs_fall   = post_vs_d & ~post_img_vsync;
    assign start_ok  = (state == S_IDLE) && frame_start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (frame_start) next_state = S_VPRE;
            S_VPRE:     if (blk_tc) next_state = S_LINE;
            S_LINE:     if (line_end) next_state = last_row ? S_VPOST : S_HBLK;
            S_HBLK:     if (blk_tc) next_state = S_LINE;
            S_VPOST:    if (blk_tc) next_state = S_WAIT_OUT;
            S_WAIT_OUT: if (vs_fall || blk_tc) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Output logic (values registered below)
    always_comb begin
        vsync_nxt = (state == S_VPRE) || (state == S_LINE) ||
                    (state == S_HBLK) || (state == S_VPOST);
        href_nxt  = accept;
        done_nxt  = (state == S_WAIT_OUT) && (vs_fall || blk_tc);
        busy_nxt  = (next_state != S_IDLE);
    end

    // Blank / timeout down-counter, loaded with length-1 on state entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (next_state != state) begin
            case (next_state)
                S_VPRE:     blk_cnt <= BLK_W'(VS_PRE - 1);
                S_HBLK:     blk_cnt <= BLK_W'(HBLANK - 1);
                S_VPOST:    blk_cnt <= BLK_W'(VS_POST - 1);
                S_WAIT_OUT: blk_cnt <= BLK_W'(TIMEOUT - 1);
                default:    blk_cnt <= '0;
            endcase
        end else if (!blk_tc) begin
            blk_cnt <= blk_cnt - BLK_W'(1);
        end
    end

    // Row/column position and output pixel monitor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            out_cnt   <= '0;
            post_vs_d <= 1'b0;
        end else begin
            post_vs_d <= post_img_vsync;
            if (start_ok) begin
                col_cnt <= '0;
                row_cnt <= '0;
                out_cnt <= '0;
            end else begin
                if (accept) begin
                    if (line_end) begin
                        col_cnt <= '0;
                        row_cnt <= row_cnt + ROW_W'(1);
                    end else begin
                        col_cnt <= col_cnt + COL_W'(1);
                    end
                end
                // Saturating so a runaway filter cannot wrap back to a "good" count
                if ((state != S_IDLE) && post_img_vsync && post_img_href &&
                    (out_cnt != '1))
                    out_cnt <= out_cnt + OCNT_W'(1);
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_img_vsync <= 1'b0;
            per_img_href  <= 1'b0;
            per_img_gray  <= 8'h00;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
            pix_err       <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            per_img_vsync <= vsync_nxt;
            per_img_href  <= href_nxt;
            frame_done    <= done_nxt;
            busy          <= busy_nxt;
            if (accept) per_img_gray <= src_data;
            if (start_ok) begin
                pix_err <= 1'b0;
                timeout <= 1'b0;
            end else if (state == S_WAIT_OUT) begin
                if (vs_fall) begin
                    if (out_cnt != OCNT_W'(PIX_TOTAL)) pix_err <= 1'b1;
                end else if (blk_tc) begin
                    timeout <= 1'b1;
                    pix_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_img_frame_sched.sv
// Testbench for img_frame_sched (W=8, H=4, blanking 5/5/5, TIMEOUT=100).
// A stub stands in for the median filter: it replays per_img_vsync/href
// delayed by LAT cycles, and can drop one output href or hold vsync high.
module tb_img_frame_sched;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       src_valid = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic       src_ready;
    logic       per_img_vsync, per_img_href;
    logic [7:0] per_img_gray;
    logic       post_img_vsync = 1'b0;
    logic       post_img_href = 1'b0;
    logic       busy, frame_done, pix_err, timeout;

    always #5 clk = ~clk;

    img_frame_sched #(
        .IMG_H_DISP(W), .IMG_V_DISP(H), .VS_PRE(5), .HBLANK(5), .VS_POST(5),
        .TIMEOUT(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .per_img_vsync(per_img_vsync), .per_img_href(per_img_href),
        .per_img_gray(per_img_gray),
        .post_img_vsync(post_img_vsync), .post_img_href(post_img_href),
        .busy(busy), .frame_done(frame_done), .pix_err(pix_err),
        .timeout(timeout)
    );

    typedef struct {
        int vs_len;
        int bursts;
        int npix;
        int perr;
        int tout;
        int gap;
    } frame_exp_t;

    frame_exp_t exp_frames[$];
    logic [7:0] exp_pix[$];

    int checks = 0;
    int errors = 0;
    int gcyc = 0;
    int start_cyc = 0;
    int pix_idx = 0;
    bit stall_en = 0;
    bit drop_pending = 0;
    bit stuck_mode = 0;
    logic [LAT-1:0] sh_vs = '0;
    logic [LAT-1:0] sh_hr = '0;

    function automatic frame_exp_t mk_exp(int vs, int b, int n, int pe, int to, int gap);
        frame_exp_t f;
        f.vs_len = vs; f.bursts = b; f.npix = n; f.perr = pe; f.tout = to; f.gap = gap;
        return f;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Source: valid pattern relative to the cycle after frame_start is sampled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            gcyc++;
            src_valid = !(stall_en && (((gcyc - start_cyc) % 3) == 2));
            src_data  = 8'(pix_idx * 37 + 11);
            @(negedge clk);
            if (src_valid && src_ready) begin
                exp_pix.push_back(src_data);
                pix_idx++;
            end
        end
    end

    // Filter stub
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sh_vs = '0;
                sh_hr = '0;
            end else begin
                sh_vs = {sh_vs[LAT-2:0], per_img_vsync};
                sh_hr = {sh_hr[LAT-2:0], per_img_href};
            end
            @(posedge clk);
            #1;
            post_img_vsync = stuck_mode ? 1'b1 : sh_vs[LAT-1];
            if (sh_hr[LAT-1] && drop_pending) begin
                post_img_href = 1'b0;
                drop_pending  = 0;
            end else begin
                post_img_href = sh_hr[LAT-1];
            end
        end
    end

    // Monitor / scoreboard
    int  mcyc = 0, m_vs = 0, m_bursts = 0, m_npix = 0, vs_fall_cyc = 0;
    bit  href_prev = 0, vs_prev = 0;
    initial begin
        frame_exp_t f;
        logic [7:0] ep;
        forever begin
            @(negedge clk);
            mcyc++;
            if (!rst_n) begin
                m_vs = 0; m_bursts = 0; m_npix = 0;
                href_prev = 0; vs_prev = 0;
                continue;
            end
            if (per_img_href) begin
                m_npix++;
                if (!href_prev) m_bursts++;
                if (exp_pix.size() == 0) begin
                    fail_now("unexpected_pixel", int'(per_img_gray), -1);
                end else begin
                    ep = exp_pix.pop_front();
                    chk("pixel_gray", int'(per_img_gray), int'(ep));
                end
            end
            if (per_img_vsync) m_vs++;
            if (vs_prev && !per_img_vsync) vs_fall_cyc = mcyc;
            href_prev = per_img_href;
            vs_prev   = per_img_vsync;
            if (frame_done) begin
                if (exp_frames.size() == 0) begin
                    fail_now("unexpected_frame_done", 1, 0);
                end else begin
                    f = exp_frames.pop_front();
                    chk("vsync_len", m_vs, f.vs_len);
                    chk("href_bursts", m_bursts, f.bursts);
                    chk("href_count", m_npix, f.npix);
                    chk("pix_err", int'(pix_err), f.perr);
                    chk("timeout", int'(timeout), f.tout);
                    chk("busy_at_done", int'(busy), 0);
                    if (f.gap >= 0) chk("done_gap", mcyc - vs_fall_cyc, f.gap);
                end
                m_vs = 0; m_bursts = 0; m_npix = 0;
            end
        end
    end

    task automatic send_start(input bit push, input frame_exp_t f);
        @(negedge clk);
        if (push) exp_frames.push_back(f);
        start_cyc   = gcyc + 1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_frames.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_frames.size() != 0) begin
            fail_now(name, n, 2000);
            exp_frames.delete();
        end
        repeat (2) @(negedge clk);
        chk({name, "_pix_left"}, exp_pix.size(), 0);
        exp_pix.delete();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_vsync"}, int'(per_img_vsync), 0);
        chk({name, "_href"}, int'(per_img_href), 0);
        chk({name, "_gray"}, int'(per_img_gray), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(frame_done), 0);
        chk({name, "_pix_err"}, int'(pix_err), 0);
        chk({name, "_timeout"}, int'(timeout), 0);
        chk({name, "_ready"}, int'(src_ready), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got %0d expected %0d", 1, 0);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit pp;
        int n;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: always-valid source
        send_start(1, mk_exp(57, 4, 32, 0, 0, -1));
        wait_done("frame_plain");

        // 2: src_valid low every third cycle: 15 stalls, 18 bursts
        stall_en = 1;
        send_start(1, mk_exp(72, 18, 32, 0, 0, -1));
        wait_done("frame_stall");
        stall_en = 0;

        // 3: extra starts mid-frame and coincident with frame_done
        send_start(1, mk_exp(57, 4, 32, 0, 0, -1));
        repeat (20) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        pp = 1;
        n  = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (pp && !post_img_vsync) break;
            pp = post_img_vsync;
        end
        if (n >= 300) fail_now("stub_fall_wait", n, 300);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_done("frame_ignored_starts");
        repeat (100) @(negedge clk);
        chk("busy_after_ignored", int'(busy), 0);
        chk("no_extra_pix", exp_pix.size(), 0);

        // 4: stub drops one output href
        drop_pending = 1;
        send_start(1, mk_exp(57, 4, 32, 1, 0, -1));
        wait_done("frame_short");
        repeat (5) @(negedge clk);
        chk("pix_err_sticky", int'(pix_err), 1);

        // 5: next start clears the flags
        send_start(1, mk_exp(57, 4, 32, 0, 0, -1));
        chk("pix_err_cleared", int'(pix_err), 0);
        chk("timeout_cleared", int'(timeout), 0);
        wait_done("frame_clean");

        // 6: output vsync never falls -> timeout 100 cycles after WAIT_OUT
        stuck_mode = 1;
        send_start(1, mk_exp(57, 4, 32, 1, 1, 99));
        wait_done("frame_timeout");
        stuck_mode = 0;
        repeat (5) @(negedge clk);
        chk("timeout_sticky", int'(timeout), 1);

        // 7: reset during the third line
        send_start(0, mk_exp(0, 0, 0, 0, 0, -1));
        n = 0;
        while ((gcyc - start_cyc) < 34 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("line3_href_before_reset", int'(per_img_href), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_pix.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 8: clean frame after reset
        send_start(1, mk_exp(57, 4, 32, 0, 0, -1));
        wait_done("frame_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
